// File: rtl/sap_control_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sap_ctrl_pkg
//  Purpose  : Shared opcode values, T-state encoding and control-word layout
//             for the SAP-style control sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package sap_ctrl_pkg;

   // IR high-nibble opcode values; anything else behaves as NOP
   localparam logic [3:0] c_OP_NOP = 4'd0;
   localparam logic [3:0] c_OP_LDA = 4'd1;
   localparam logic [3:0] c_OP_ADD = 4'd2;
   localparam logic [3:0] c_OP_SUB = 4'd3;
   localparam logic [3:0] c_OP_OUT = 4'd4;
   localparam logic [3:0] c_OP_HLT = 4'd15;

   // T-states are encoded 1..6 so the debug output reads naturally;
   // 0 and 7 are illegal and recover to T1
   typedef enum logic [2:0] {
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4,
      T5 = 3'd5,
      T6 = 3'd6
   } tstate_t;

   // Opcode class after folding unknown values into NOP
   typedef enum logic [2:0] {
      INS_NOP = 3'd0,
      INS_LDA = 3'd1,
      INS_ADD = 3'd2,
      INS_SUB = 3'd3,
      INS_OUT = 3'd4,
      INS_HLT = 3'd5
   } instr_t;

   // One field per datapath control pin
   typedef struct packed {
      logic enablePC;
      logic incPC;
      logic latchMAR;
      logic enableRAM;
      logic latchIR;
      logic enableIR;
      logic latchA;
      logic enableA;
      logic latchB;
      logic enableALU;
      logic sub;
      logic latchOut;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '0;

endpackage : sap_ctrl_pkg
`default_nettype wire

// File: rtl/sap_control_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : sap_control_sequencer_if
//  Purpose  : Run/opcode inputs and control-word outputs exchanged between
//             the sequencer (master) and the datapath (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface sap_control_sequencer_if #(
   parameter int OPW = 4
);
   logic           Run;
   logic [OPW-1:0] Opcode;
   logic           EnablePC;
   logic           IncPC;
   logic           LatchMAR;
   logic           EnableRAM;
   logic           LatchIR;
   logic           EnableIR;
   logic           LatchA;
   logic           EnableA;
   logic           LatchB;
   logic           EnableALU;
   logic           Sub;
   logic           LatchOut;
   logic           Halted;
   logic [2:0]     TState;

   modport master (
      input  Run, Opcode,
      output EnablePC, IncPC, LatchMAR, EnableRAM, LatchIR, EnableIR,
             LatchA, EnableA, LatchB, EnableALU, Sub, LatchOut,
             Halted, TState
   );

   modport slave (
      output Run, Opcode,
      input  EnablePC, IncPC, LatchMAR, EnableRAM, LatchIR, EnableIR,
             LatchA, EnableA, LatchB, EnableALU, Sub, LatchOut,
             Halted, TState
   );

endinterface : sap_control_sequencer_if
`default_nettype wire

// File: rtl/sap_control_sequencer_decode.sv
`default_nettype none
// ============================================================================
//  Module   : sap_ctrl_decode
//  Purpose  : Pure combinational map (T-state, opcode) -> control word, plus
//             the last-step and halt-step flags used by the sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module sap_ctrl_decode
   import sap_ctrl_pkg::*;
#(
   parameter int OPW       = 4,
   parameter int FIXED_LEN = 0
) (
   input  tstate_t        tState,
   input  logic [OPW-1:0] opcode,
   output ctrl_t          ctrlWord,
   output logic           isLast,
   output logic           haltStep
);

   instr_t w_instr;
   logic   w_varLast;

   // Fold the raw opcode into an instruction class; unknown values are NOP
   always_comb begin
      w_instr = INS_NOP;
      if (opcode == OPW'(c_OP_LDA))      w_instr = INS_LDA;
      else if (opcode == OPW'(c_OP_ADD)) w_instr = INS_ADD;
      else if (opcode == OPW'(c_OP_SUB)) w_instr = INS_SUB;
      else if (opcode == OPW'(c_OP_OUT)) w_instr = INS_OUT;
      else if (opcode == OPW'(c_OP_HLT)) w_instr = INS_HLT;
   end

   // Per-step control word; each step enables at most one driver and one latch
   always_comb begin
      ctrlWord  = CTRL_IDLE;
      w_varLast = 1'b0;
      haltStep  = 1'b0;
      case (tState)
         T1: begin
            ctrlWord.enablePC = 1'b1;
            ctrlWord.latchMAR = 1'b1;
         end
         T2: ctrlWord.incPC = 1'b1;
         T3: begin
            ctrlWord.enableRAM = 1'b1;
            ctrlWord.latchIR   = 1'b1;
         end
         T4: begin
            case (w_instr)
               INS_LDA, INS_ADD, INS_SUB: begin
                  ctrlWord.enableIR = 1'b1;
                  ctrlWord.latchMAR = 1'b1;
               end
               INS_OUT: begin
                  ctrlWord.enableA  = 1'b1;
                  ctrlWord.latchOut = 1'b1;
                  w_varLast         = 1'b1;
               end
               INS_HLT: begin
                  haltStep  = 1'b1;
                  w_varLast = 1'b1;
               end
               default: w_varLast = 1'b1;
            endcase
         end
         T5: begin
            case (w_instr)
               INS_LDA: begin
                  ctrlWord.enableRAM = 1'b1;
                  ctrlWord.latchA    = 1'b1;
                  w_varLast          = 1'b1;
               end
               INS_ADD, INS_SUB: begin
                  ctrlWord.enableRAM = 1'b1;
                  ctrlWord.latchB    = 1'b1;
               end
               default: w_varLast = 1'b1;
            endcase
         end
         T6: begin
            w_varLast = 1'b1;
            if (w_instr == INS_ADD || w_instr == INS_SUB) begin
               ctrlWord.enableALU = 1'b1;
               ctrlWord.latchA    = 1'b1;
               ctrlWord.sub       = (w_instr == INS_SUB);
            end
         end
         default: ;
      endcase
   end

   // Fixed-length builds always run the full six steps
   assign isLast = (FIXED_LEN != 0) ? (tState == T6) : w_varLast;

endmodule : sap_ctrl_decode
`default_nettype wire

// File: rtl/sap_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sap_control_sequencer
//  Purpose  : T-state counter, run/halt handling and Clear override for the
//             SAP-style CPU; drives the per-cycle datapath control word.
//  Revision : 1.0  initial release
// ============================================================================
module sap_control_sequencer
   import sap_ctrl_pkg::*;
#(
   parameter int OPW        = 4,
   parameter int FIXED_LEN  = 0,
   parameter int HLT_STICKY = 1
) (
   input  wire logic               MainClock,
   input  wire logic               Clear,
   sap_control_sequencer_if.master bus
);

   tstate_t r_tState;
   tstate_t w_nextState;
   logic    r_halted;
   logic    w_nextHalted;
   logic    r_runPrev;
   logic    w_runRise;
   logic    w_legal;
   logic    w_isLast;
   logic    w_haltStep;
   ctrl_t   w_decWord;
   ctrl_t   w_ctrl;

   sap_ctrl_decode #(
      .OPW       (OPW),
      .FIXED_LEN (FIXED_LEN)
   ) u_decode (
      .tState   (r_tState),
      .opcode   (bus.Opcode),
      .ctrlWord (w_decWord),
      .isLast   (w_isLast),
      .haltStep (w_haltStep)
   );

   assign w_legal   = r_tState inside {T1, T2, T3, T4, T5, T6};
   assign w_runRise = bus.Run & ~r_runPrev;

   // State, halt flag and Run history; Clear wins over everything
   always_ff @(posedge MainClock) begin
      if (Clear) begin
         r_tState  <= T1;
         r_halted  <= 1'b0;
         r_runPrev <= 1'b0;
      end else begin
         r_tState  <= w_nextState;
         r_halted  <= w_nextHalted;
         r_runPrev <= bus.Run;
      end
   end

   // Next T-state: park in T1 when not running, freeze while halted
   always_comb begin
      w_nextState  = r_tState;
      w_nextHalted = r_halted;
      if (!w_legal) begin
         w_nextState = T1;
      end else if (r_halted) begin
         if (HLT_STICKY == 0 && w_runRise) begin
            w_nextHalted = 1'b0;
            w_nextState  = T1;
         end
      end else begin
         case (r_tState)
            T1: if (bus.Run) w_nextState = T2;
            T2: w_nextState = T3;
            T3: w_nextState = T4;
            T4: begin
               if (w_haltStep)    w_nextHalted = 1'b1;
               else if (w_isLast) w_nextState  = T1;
               else               w_nextState  = T5;
            end
            T5: w_nextState = w_isLast ? T1 : T6;
            default: w_nextState = T1;
         endcase
      end
   end

   // Output gating: Clear, halt, a parked T1 or an illegal state give idle
   always_comb begin
      w_ctrl = CTRL_IDLE;
      if (!Clear && !r_halted && w_legal && !(r_tState == T1 && !bus.Run))
         w_ctrl = w_decWord;
   end

   assign bus.EnablePC  = w_ctrl.enablePC;
   assign bus.IncPC     = w_ctrl.incPC;
   assign bus.LatchMAR  = w_ctrl.latchMAR;
   assign bus.EnableRAM = w_ctrl.enableRAM;
   assign bus.LatchIR   = w_ctrl.latchIR;
   assign bus.EnableIR  = w_ctrl.enableIR;
   assign bus.LatchA    = w_ctrl.latchA;
   assign bus.EnableA   = w_ctrl.enableA;
   assign bus.LatchB    = w_ctrl.latchB;
   assign bus.EnableALU = w_ctrl.enableALU;
   assign bus.Sub       = w_ctrl.sub;
   assign bus.LatchOut  = w_ctrl.latchOut;
   assign bus.Halted    = r_halted;
   assign bus.TState    = r_tState;

endmodule : sap_control_sequencer
`default_nettype wire

// File: tb/tb_sap_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sap_control_sequencer
//  Purpose  : Self-checking bench for three sequencer builds:
//             dut0 variable length / sticky halt, dut1 fixed length,
//             dut2 variable length / Run-resumable halt.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sap_control_sequencer;

   // Bit positions of the observed control vector
   localparam int c_EPC  = 11;
   localparam int c_IPC  = 10;
   localparam int c_LMAR = 9;
   localparam int c_ERAM = 8;
   localparam int c_LIR  = 7;
   localparam int c_EIR  = 6;
   localparam int c_LA   = 5;
   localparam int c_EA   = 4;
   localparam int c_LB   = 3;
   localparam int c_EALU = 2;
   localparam int c_SUB  = 1;
   localparam int c_LOUT = 0;

   logic        clk = 1'b0;
   logic [2:0]  clear;
   logic [2:0]  run;
   logic [3:0]  opcode [3];
   logic [11:0] ctrlV  [3];
   logic [2:0]  tst    [3];
   logic        hlt    [3];
   int          nTests = 0;
   int          nFail  = 0;

   always #5 clk = ~clk;

   // Three DUT builds, each with its own interface instance
   for (genvar g = 0; g < 3; g++) begin : g_dut
      sap_control_sequencer_if #(.OPW(4)) u_if ();
      sap_control_sequencer #(
         .OPW        (4),
         .FIXED_LEN  ((g == 1) ? 1 : 0),
         .HLT_STICKY ((g == 2) ? 0 : 1)
      ) u_dut (
         .MainClock (clk),
         .Clear     (clear[g]),
         .bus       (u_if.master)
      );
      assign u_if.Run    = run[g];
      assign u_if.Opcode = opcode[g];
      assign ctrlV[g] = {u_if.EnablePC, u_if.IncPC, u_if.LatchMAR, u_if.EnableRAM,
                         u_if.LatchIR, u_if.EnableIR, u_if.LatchA, u_if.EnableA,
                         u_if.LatchB, u_if.EnableALU, u_if.Sub, u_if.LatchOut};
      assign tst[g] = u_if.TState;
      assign hlt[g] = u_if.Halted;
   end

   // ---------------- reference model ----------------
   // Expected control word for opcode op in T-state t
   function automatic logic [11:0] expCtrl(input int op, input int t);
      logic [11:0] w;
      bit isMem;
      w = '0;
      isMem = (op == 1 || op == 2 || op == 3);
      if (t == 1) begin w[c_EPC] = 1'b1; w[c_LMAR] = 1'b1; end
      if (t == 2) w[c_IPC] = 1'b1;
      if (t == 3) begin w[c_ERAM] = 1'b1; w[c_LIR] = 1'b1; end
      if (t == 4 && isMem)   begin w[c_EIR] = 1'b1; w[c_LMAR] = 1'b1; end
      if (t == 4 && op == 4) begin w[c_EA] = 1'b1; w[c_LOUT] = 1'b1; end
      if (t == 5 && op == 1) begin w[c_ERAM] = 1'b1; w[c_LA] = 1'b1; end
      if (t == 5 && (op == 2 || op == 3)) begin w[c_ERAM] = 1'b1; w[c_LB] = 1'b1; end
      if (t == 6 && (op == 2 || op == 3)) begin
         w[c_EALU] = 1'b1; w[c_LA] = 1'b1; w[c_SUB] = (op == 3);
      end
      return w;
   endfunction

   // Instruction length in cycles
   function automatic int expLen(input int op, input bit fixedLen);
      if (op == 15) return 4;
      if (fixedLen) return 6;
      if (op == 1) return 5;
      if (op == 2 || op == 3) return 6;
      return 4;
   endfunction

   // Bus exclusivity watch on every DUT, every cycle
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         nTests++;
         if ($countones({ctrlV[k][c_EPC], ctrlV[k][c_ERAM], ctrlV[k][c_EIR],
                         ctrlV[k][c_EA], ctrlV[k][c_EALU]}) > 1) begin
            nFail++;
            $display("FAIL bus_drivers dut%0d: got %b want at most one enable", k, ctrlV[k]);
         end
         nTests++;
         if ($countones({ctrlV[k][c_LMAR], ctrlV[k][c_LIR], ctrlV[k][c_LA],
                         ctrlV[k][c_LB], ctrlV[k][c_LOUT]}) > 1) begin
            nFail++;
            $display("FAIL bus_latches dut%0d: got %b want at most one latch", k, ctrlV[k]);
         end
      end
   end

   // Runs one instruction starting in T1; optional Clear abort or Run drop
   task automatic exec(input int k, input int op, input int abortAt, input int dropRunAt);
      int len;
      logic [11:0] e;
      len = expLen(op, k == 1);
      run[k] = 1'b1;
      #1;
      for (int t = 1; t <= len; t++) begin
         if (t == abortAt) begin
            clear[k] = 1'b1;
            #1;
            nTests++;
            if (ctrlV[k] !== 12'h000) begin
               nFail++;
               $display("FAIL abort_ctrl dut%0d: got %b want 0", k, ctrlV[k]);
            end
            @(negedge clk); #1;
            nTests++;
            if (tst[k] !== 3'd1 || hlt[k] !== 1'b0) begin
               nFail++;
               $display("FAIL abort_state dut%0d: got t%0d h%b want t1 h0", k, tst[k], hlt[k]);
            end
            clear[k] = 1'b0;
            #1;
            return;
         end
         e = expCtrl(op, t);
         nTests++;
         if (tst[k] !== 3'(t)) begin
            nFail++;
            $display("FAIL tstate dut%0d op%0d: got %0d want %0d", k, op, tst[k], t);
         end
         nTests++;
         if (ctrlV[k] !== e) begin
            nFail++;
            $display("FAIL ctrl dut%0d op%0d t%0d: got %b want %b", k, op, t, ctrlV[k], e);
         end
         if (t == 3) opcode[k] = 4'(op);
         if (t == dropRunAt) run[k] = 1'b0;
         @(negedge clk); #1;
      end
      if (op == 15) begin
         nTests++;
         if (hlt[k] !== 1'b1 || tst[k] !== 3'd4 || ctrlV[k] !== 12'h000) begin
            nFail++;
            $display("FAIL halt_entry dut%0d: got h%b t%0d c%b want h1 t4 c0", k, hlt[k], tst[k], ctrlV[k]);
         end
      end else if (dropRunAt != 0) begin
         repeat (2) begin
            nTests++;
            if (tst[k] !== 3'd1 || ctrlV[k] !== 12'h000) begin
               nFail++;
               $display("FAIL park dut%0d: got t%0d c%b want t1 c0", k, tst[k], ctrlV[k]);
            end
            @(negedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      clear = 3'b111;
      run   = 3'b111;
      repeat (3) begin
         @(negedge clk); #1;
         for (int k = 0; k < 3; k++) begin
            nTests++;
            if (ctrlV[k] !== 12'h000 || tst[k] !== 3'd1 || hlt[k] !== 1'b0) begin
               nFail++;
               $display("FAIL reset dut%0d: got c%b t%0d h%b want c0 t1 h0", k, ctrlV[k], tst[k], hlt[k]);
            end
         end
      end
      run   = 3'b000;
      clear = 3'b000;
      @(negedge clk); #1;
      for (int k = 0; k < 3; k++) begin
         nTests++;
         if (ctrlV[k] !== 12'h000 || tst[k] !== 3'd1) begin
            nFail++;
            $display("FAIL park_idle dut%0d: got c%b t%0d want c0 t1", k, ctrlV[k], tst[k]);
         end
      end
   endtask

   task automatic test_basic_ops();
      exec(0, 0, 0, 0);   // NOP
      exec(0, 9, 0, 0);   // unknown -> NOP
      exec(0, 1, 0, 0);   // LDA
      exec(0, 3, 0, 0);   // SUB
      exec(0, 2, 0, 0);   // ADD
      exec(0, 4, 0, 0);   // OUT
      run[0] = 1'b0;
   endtask

   task automatic test_fixed_len();
      exec(1, 4, 0, 0);
      exec(1, 1, 0, 0);
      exec(1, 0, 0, 0);
      exec(1, 3, 0, 0);
      run[1] = 1'b0;
   endtask

   task automatic test_clear_mid();
      exec(0, 2, 5, 0);   // abort ADD in T5
      exec(0, 1, 0, 0);
      run[0] = 1'b0;
   endtask

   task automatic test_run_park();
      exec(0, 1, 0, 2);
      exec(0, 2, 0, 0);
      run[0] = 1'b0;
   endtask

   task automatic test_halt();
      exec(0, 15, 0, 0);
      for (int i = 0; i < 10; i++) begin
         if (i == 3) run[0] = 1'b0;
         if (i == 5) run[0] = 1'b1;
         @(negedge clk); #1;
         nTests++;
         if (ctrlV[0] !== 12'h000 || tst[0] !== 3'd4 || hlt[0] !== 1'b1) begin
            nFail++;
            $display("FAIL halt_hold cyc%0d: got c%b t%0d h%b want c0 t4 h1", i, ctrlV[0], tst[0], hlt[0]);
         end
      end
      clear[0] = 1'b1;
      @(negedge clk); #1;
      nTests++;
      if (hlt[0] !== 1'b0 || tst[0] !== 3'd1) begin
         nFail++;
         $display("FAIL halt_clear: got h%b t%0d want h0 t1", hlt[0], tst[0]);
      end
      clear[0] = 1'b0;
      exec(0, 4, 0, 0);
      run[0] = 1'b0;
   endtask

   task automatic test_halt_resume();
      exec(2, 15, 0, 0);
      run[2] = 1'b0;
      @(negedge clk); #1;
      nTests++;
      if (hlt[2] !== 1'b1) begin
         nFail++;
         $display("FAIL resume_hold: got h%b want h1", hlt[2]);
      end
      run[2] = 1'b1;
      @(negedge clk); #1;
      nTests++;
      if (hlt[2] !== 1'b0 || tst[2] !== 3'd1 || ctrlV[2] !== expCtrl(0, 1)) begin
         nFail++;
         $display("FAIL resume: got h%b t%0d c%b want h0 t1 fetch", hlt[2], tst[2], ctrlV[2]);
      end
      exec(2, 3, 0, 0);
      run[2] = 1'b0;
   endtask

   task automatic test_random();
      for (int k = 0; k < 3; k++) begin
         for (int i = 0; i < 12; i++) begin
            int op;
            int drop;
            op   = int'($urandom_range(0, 14));
            drop = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 4)) : 0;
            exec(k, op, 0, drop);
         end
         run[k] = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1);
   end

   initial begin
      clear = 3'b111;
      run   = 3'b000;
      for (int k = 0; k < 3; k++) opcode[k] = 4'd0;
      test_reset();
      test_basic_ops();
      test_fixed_len();
      test_clear_mid();
      test_run_park();
      test_halt();
      test_halt_resume();
      test_random();
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule : tb_sap_control_sequencer
`default_nettype wire
